// File: rtl/register_bank.sv
// Bank of general-purpose registers with a single-issue operation port.
// Single-cycle ops complete on the accept edge; shifts/rotates step one bit per cycle.
module register_bank #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [3:0]             op,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   sin,
  input  logic [ADDR_WIDTH-1:0]  raddr_a,
  input  logic [ADDR_WIDTH-1:0]  raddr_b,
  output logic [DATA_WIDTH-1:0]  out_a,
  output logic [DATA_WIDTH-1:0]  out_b,
  output logic                   done,
  output logic [3:0]             flags
);

  localparam int unsigned DW1 = DATA_WIDTH + 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0]  regs [REG_COUNT];
  logic [0:0]             state, state_next;
  logic [SHAMT_WIDTH-1:0] cnt, cnt_next;
  logic [DATA_WIDTH-1:0]  shadow, shadow_next;
  logic [ADDR_WIDTH-1:0]  sh_addr, sh_addr_next;
  logic [3:0]             sh_op, sh_op_next;
  logic                   sh_sin, sh_sin_next;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [3:0]             flags_next;
  logic                   done_next;
  logic                   ready_next;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  cur;
  logic [DATA_WIDTH-1:0]  step_val;
  logic                   step_out;

  // One shift/rotate step: returns {bit shifted out, new value}.
  function automatic logic [DW1-1:0] shift1(input logic [3:0] code,
                                            input logic [DATA_WIDTH-1:0] v,
                                            input logic fill);
    case (code)
      OP_SHR:  shift1 = {v[0], fill, v[DATA_WIDTH-1:1]};
      OP_SHL:  shift1 = {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], fill};
      OP_ASR:  shift1 = {v[0], v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      OP_ROR:  shift1 = {v[0], v[0], v[DATA_WIDTH-1:1]};
      OP_ROL:  shift1 = {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
      default: shift1 = {1'b0, v};
    endcase
  endfunction

  assign out_a = regs[raddr_a];
  assign out_b = regs[raddr_b];

  // Next-state, register write and flag computation
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shadow_next  = shadow;
    sh_addr_next = sh_addr;
    sh_op_next   = sh_op;
    sh_sin_next  = sh_sin;
    wr_en        = 1'b0;
    wr_addr      = waddr;
    wr_data      = '0;
    flags_next   = flags;
    done_next    = 1'b0;
    accept       = op_valid && op_ready;
    cur          = regs[waddr];
    {step_out, step_val} = shift1(sh_op, shadow, sh_sin);

    case (state)
      ST_IDLE: begin
        if (accept) begin
          done_next = 1'b1;
          case (op)
            OP_CLR: begin
              wr_en      = 1'b1;
              wr_data    = '0;
              flags_next = 4'b1000;
            end
            OP_LD: begin
              wr_en      = 1'b1;
              wr_data    = in;
              flags_next = {in == '0, in[DATA_WIDTH-1], 2'b00};
            end
            OP_INC: begin
              wr_en      = 1'b1;
              wr_data    = cur + DATA_WIDTH'(1);
              flags_next = {wr_data == '0, wr_data[DATA_WIDTH-1], &cur, cur == SMAX};
            end
            OP_DEC: begin
              wr_en      = 1'b1;
              wr_data    = cur - DATA_WIDTH'(1);
              flags_next = {wr_data == '0, wr_data[DATA_WIDTH-1], cur == '0, cur == SMIN};
            end
            OP_SHR, OP_SHL, OP_ASR, OP_ROR, OP_ROL: begin
              if (shamt == '0) begin
                wr_en      = 1'b1;
                wr_data    = cur;
                flags_next = {cur == '0, cur[DATA_WIDTH-1], 2'b00};
              end else begin
                done_next    = 1'b0;
                state_next   = ST_SHIFT;
                cnt_next     = shamt;
                shadow_next  = cur;
                sh_addr_next = waddr;
                sh_op_next   = op;
                sh_sin_next  = sin;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        shadow_next = step_val;
        cnt_next    = cnt - SHAMT_WIDTH'(1);
        if (cnt == SHAMT_WIDTH'(1)) begin
          wr_en      = 1'b1;
          wr_addr    = sh_addr;
          wr_data    = step_val;
          flags_next = {step_val == '0, step_val[DATA_WIDTH-1], step_out, 1'b0};
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    ready_next = (state_next == ST_IDLE);
  end

  // State and register array; reset aborts any shift in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      sh_addr  <= '0;
      sh_op    <= OP_NOP;
      sh_sin   <= 1'b0;
      flags    <= 4'b0000;
      done     <= 1'b0;
      op_ready <= 1'b1;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      state    <= state_next;
      cnt      <= cnt_next;
      shadow   <= shadow_next;
      sh_addr  <= sh_addr_next;
      sh_op    <= sh_op_next;
      sh_sin   <= sh_sin_next;
      flags    <= flags_next;
      done     <= done_next;
      op_ready <= ready_next;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (16-bit x 8 registers).
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op;
  logic [2:0]  waddr;
  logic [15:0] in;
  logic [3:0]  shamt;
  logic        sin;
  logic [2:0]  raddr_a, raddr_b;
  logic [15:0] out_a, out_b;
  logic        done;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  register_bank dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .waddr(waddr), .in(in), .shamt(shamt), .sin(sin), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .out_a(out_a), .out_b(out_b), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one request for a single edge, then drop op_valid; returns 1ns after the edge.
  task automatic issue(input logic [3:0] o, input logic [2:0] a, input logic [15:0] d,
                       input logic [3:0] s, input logic f);
    op = o; waddr = a; in = d; shamt = s; sin = f; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op = 4'd0; waddr = '0; in = '0; shamt = '0; sin = 1'b0;
    raddr_a = '0; raddr_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      raddr_a = 3'(r); raddr_b = 3'(7 - r);
      #1;
      checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_out_a r%0d: got %h want 0000", r, out_a); end
      checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL reset_out_b r%0d: got %h want 0000", 7 - r, out_b); end
    end
  endtask

  task automatic test_arith;
    raddr_a = 3'd3; raddr_b = 3'd0;
    issue(4'd2, 3'd3, 16'h7FFF, 4'd0, 1'b0);
    checks++; if (out_a !== 16'h7FFF) begin errors++; $display("FAIL ld_r3: got %h want 7fff", out_a); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ld_done: got %b want 1", done); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL ld_flags: got %b want 0000", flags); end
    issue(4'd3, 3'd3, 16'h0000, 4'd0, 1'b0);
    checks++; if (out_a !== 16'h8000) begin errors++; $display("FAIL inc_r3: got %h want 8000", out_a); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL inc_flags: got %b want 0101", flags); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL inc_done_b2b: got %b want 1", done); end
    issue(4'd4, 3'd0, 16'h0000, 4'd0, 1'b0);
    checks++; if (out_b !== 16'hFFFF) begin errors++; $display("FAIL dec_r0: got %h want ffff", out_b); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL dec_flags: got %b want 0110", flags); end
    issue(4'd4, 3'd3, 16'h0000, 4'd0, 1'b0);
    checks++; if (out_a !== 16'h7FFF) begin errors++; $display("FAIL dec_smin: got %h want 7fff", out_a); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL dec_smin_flags: got %b want 0001", flags); end
    issue(4'd3, 3'd0, 16'h0000, 4'd0, 1'b0);
    checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", out_b); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL inc_wrap_flags: got %b want 1010", flags); end
    issue(4'd1, 3'd3, 16'h0000, 4'd0, 1'b0);
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL clr_r3: got %h want 0000", out_a); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL clr_flags: got %b want 1000", flags); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b want 0", done); end
  endtask

  task automatic test_shl;
    raddr_a = 3'd1;
    issue(4'd2, 3'd1, 16'h8001, 4'd0, 1'b0);
    issue(4'd6, 3'd1, 16'h0000, 4'd3, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL shl_ready c%0d: got %b want 0", c, op_ready); end
      checks++; if (out_a !== 16'h8001) begin errors++; $display("FAIL shl_pre c%0d: got %h want 8001", c, out_a); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL shl_busy_done c%0d: got %b want 0", c, done); end
    end
    @(posedge clk); #1;
    checks++; if (out_a !== 16'h000F) begin errors++; $display("FAIL shl_result: got %h want 000f", out_a); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL shl_flags: got %b want 0000", flags); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL shl_done: got %b want 1", done); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL shl_ready_end: got %b want 1", op_ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL shl_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_shifts;
    int n;
    raddr_a = 3'd4; raddr_b = 3'd5;
    issue(4'd2, 3'd4, 16'h8000, 4'd0, 1'b0);
    issue(4'd7, 3'd4, 16'h0000, 4'd15, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 15) begin errors++; $display("FAIL asr_latency: got %0d want 15", n); end
    checks++; if (out_a !== 16'hFFFF) begin errors++; $display("FAIL asr_result: got %h want ffff", out_a); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL asr_flags: got %b want 0100", flags); end
    issue(4'd2, 3'd5, 16'h0001, 4'd0, 1'b0);
    issue(4'd8, 3'd5, 16'h0000, 4'd1, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 1) begin errors++; $display("FAIL ror_latency: got %0d want 1", n); end
    checks++; if (out_b !== 16'h8000) begin errors++; $display("FAIL ror_result: got %h want 8000", out_b); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL ror_flags: got %b want 0110", flags); end
    issue(4'd9, 3'd5, 16'h0000, 4'd0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rol0_done: got %b want 1", done); end
    checks++; if (out_b !== 16'h8000) begin errors++; $display("FAIL rol0_value: got %h want 8000", out_b); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL rol0_flags: got %b want 0100", flags); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rol0_ready: got %b want 1", op_ready); end
    issue(4'd9, 3'd5, 16'h0000, 4'd1, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (out_b !== 16'h0001) begin errors++; $display("FAIL rol_result: got %h want 0001", out_b); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL rol_flags: got %b want 0010", flags); end
    issue(4'd2, 3'd4, 16'h000F, 4'd0, 1'b0);
    issue(4'd5, 3'd4, 16'h0000, 4'd2, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (out_a !== 16'h0003) begin errors++; $display("FAIL shr_result: got %h want 0003", out_a); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL shr_flags: got %b want 0010", flags); end
  endtask

  task automatic test_hold_during_shift;
    int n;
    raddr_a = 3'd6; raddr_b = 3'd7;
    issue(4'd2, 3'd6, 16'h00F0, 4'd0, 1'b0);
    op = 4'd5; waddr = 3'd6; shamt = 4'd4; sin = 1'b0; op_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd2; waddr = 3'd7; in = 16'h1234; shamt = 4'd0;
    n = 0;
    while (op_ready !== 1'b1 && n < 20) begin
      checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL hold_ld_early n%0d: got %h want 0000", n, out_b); end
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_busy_cycles: got %0d want 4", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_shift_done: got %b want 1", done); end
    checks++; if (out_a !== 16'h000F) begin errors++; $display("FAIL hold_shift_result: got %h want 000f", out_a); end
    checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL hold_ld_not_yet: got %h want 0000", out_b); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (out_b !== 16'h1234) begin errors++; $display("FAIL hold_ld_value: got %h want 1234", out_b); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_ld_done: got %b want 1", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_ld_once: got %b want 0", done); end
  endtask

  task automatic test_undefined_op;
    raddr_a = 3'd0;
    issue(4'd2, 3'd0, 16'h8000, 4'd0, 1'b0);
    issue(4'd12, 3'd0, 16'h5555, 4'd3, 1'b1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL op12_done: got %b want 1", done); end
    checks++; if (out_a !== 16'h8000) begin errors++; $display("FAIL op12_value: got %h want 8000", out_a); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL op12_flags: got %b want 0100", flags); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL op12_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_reset_mid_shift;
    raddr_a = 3'd1; raddr_b = 3'd7;
    issue(4'd2, 3'd1, 16'h00FF, 4'd0, 1'b0);
    issue(4'd6, 3'd1, 16'h0000, 4'd5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL rstmid_target: got %h want 0000", out_a); end
    checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL rstmid_other: got %h want 0000", out_b); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", op_ready); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", flags); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done c%0d: got %b want 0", c, done); end
      @(posedge clk); #1;
    end
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL rstmid_target_late: got %h want 0000", out_a); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shl();
    test_shifts();
    test_hold_during_shift();
    test_undefined_op();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
